muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
// - Iterative RV32M multiply/divide unit for the EX stage, beside the single-cycle ALU.
// - Decode steers M-extension ops here instead of the ALU, and this block stalls the pipeline until the result is ready.
// - A one-hot FSM sequences a shared shift/add-subtract datapath, one bit per cycle.
// - Special divide cases are resolved in a single cycle.
// PARAMETERS
// - XLEN   32              operand/result width
// - CNT_W  $clog2(XLEN)    iteration counter width (derived, not overridden)
// PORTS
// - clk      in   1     single clock, rising edge
// - rst      in   1     asynchronous, active-high reset
// - start    in   1     EX holds a valid M-extension op (funct7=0000001)
// - funct3   in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// - op_a     in   XLEN  rs1 value (forwarded)
// - op_b     in   XLEN  rs2 value (forwarded)
// - flush    in   1     kill the in-flight op (branch/exception flush of EX)
// - stall    out  1     freeze IF/ID/EX; combinational
// - busy     out  1     state != IDLE
// - done     out  1     one-cycle pulse: result is valid
// - result   out  XLEN  registered result; held until the next accepted start
// BEHAVIOUR
// - Reset (async): state=IDLE; done=0; busy=0; result=0; counter=0.
// - States: IDLE, CALC, FIX, DONE.
//   - IDLE: start=1 latches funct3 and operands.
//     - DIV/REM with op_b==0, or signed op_a==0x80000000 with op_b==-1 -> DONE (fast path).
//     - Otherwise -> CALC, with counter=XLEN-1.
//   - CALC: one iteration per cycle.
//     - MUL*: shift-add on the magnitude of the 2*XLEN product.
//     - DIV*/REM*: restoring divide, one quotient bit per cycle.
//     - counter==0 -> FIX; else counter-1.
//   - FIX: apply the sign, then select low word (MUL, quotient, remainder) or high word (MULH*). -> DONE.
//   - DONE: done=1 for exactly one cycle; -> IDLE.
// - Signedness:
//   - MULH: both operands signed. MULHSU: op_a signed, op_b unsigned. MULHU/DIVU/REMU: unsigned.
//   - Signed ops use absolute values internally.
//   - Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sign of dividend.
//   - Negate in FIX using the 2*XLEN two's complement.
// - Special cases (fast path, RISC-V spec values):
//   - x/0: quotient = all ones; remainder = op_a.
//   - Signed overflow 0x80000000/-1: quotient = 0x80000000; remainder = 0.
// - Latency, with start in cycle 0:
//   - Iterative: done in cycle XLEN+2 (34).
//   - Fast path: done in cycle 1.
// - stall = (state==IDLE & start) | state==CALC | state==FIX.
//   - stall is low in DONE, so EX advances in that cycle and captures result.
// - start while busy: ignored. In DONE, start is ignored that cycle; the held instruction re-raises it after IDLE only if it is a new op.
// - flush:
//   - In any state -> IDLE next edge; done is never raised for the killed op.
//   - flush & start in the same IDLE cycle: no op accepted.
//   - flush in DONE: done is still high that cycle; EX ignores it.
// - result changes only on the FIX->DONE edge or a fast-path entry into DONE.
// - Async rst mid-operation: immediate IDLE, all outputs at their reset values.
// STRUCTURE
// - Package muldiv_pkg holds:
//   - funct3 localparams (F3_MUL..F3_REMU)
//   - state encoding (S_IDLE, S_CALC, S_FIX, S_DONE)
//   - XLEN default
// - Sub-module muldiv_iter_dp holds the datapath:
//   - acc/quotient shift registers and the adder/subtractor
//   - ports: load, step, is_div, fix_sign, neg, sel_hi
// - The top level keeps the FSM, counter, special-case detect, stall/done logic and result register.
// TESTING
// - MUL 7*6: start in cycle 0 -> stall cycles 0..33, done in cycle 34, result=0x0000002A.
// - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU -1*2 -> 0xFFFFFFFF.
// - DIV -7/2 -> 0xFFFFFFFD. REM -7%2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
// - DIV 5/0 -> done in cycle 1, 0xFFFFFFFF. REM 5%0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM same operands -> 0.
// - MUL started, flush in cycle 10 -> busy=0 in cycle 11, no done pulse.
//   A fresh DIVU 100/7 in cycle 12 -> done in cycle 46, result 14.
// - start toggled during CALC -> ignored, one done only.
//   Async rst in cycle 20 -> outputs are 0 immediately, and the next op completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, state encoding and operand-signedness helpers for the RV32M unit
package muldiv_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_CALC = 4'b0010,
    S_FIX  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;
  function automatic logic signed_a(input logic [2:0] f3);
    return f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_DIV || f3 == F3_REM;
  endfunction
  function automatic logic signed_b(input logic [2:0] f3);
    return f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM;
  endfunction
endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp: shared shift/add-subtract datapath; {hi,lo} holds the product, or remainder/quotient
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic            fix_sign,
  input  logic            neg,
  input  logic            sel_hi,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] res
);
  logic [XLEN-1:0]   hi, lo, bq;
  logic [XLEN:0]     mul_sum, shl, diff;
  logic [2*XLEN-1:0] wide, fixed;
  // one multiply add-shift step or one restoring-divide trial, plus final sign/word selection
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
    shl     = {hi, lo[XLEN-1]};
    diff    = shl - {1'b0, bq};
    wide    = is_div ? {{XLEN{1'b0}}, (sel_hi ? hi : lo)} : {hi, lo};
    fixed   = (fix_sign && neg) ? -wide : wide;
    res     = (sel_hi && !is_div) ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
  end
  // operand load and per-cycle iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      bq <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a_mag;
      bq <= b_mag;
    end else if (step) begin
      hi <= is_div ? (diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0]) : mul_sum[XLEN:1];
      lo <= is_div ? {lo[XLEN-2:0], ~diff[XLEN]} : {mul_sum[0], lo[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with pipeline stall, flush and fast-path divide cases
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic             neg_q, accept, special, div0, ovf, sa, sb;
  logic [XLEN-1:0]  fast_val, a_mag, b_mag, dp_res;
  // accept/special-case decode, operand magnitudes and next state
  always_comb begin
    accept   = state == S_IDLE && start && !flush;
    div0     = op_b == '0;
    ovf      = !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
    special  = funct3[2] && (div0 || ovf);
    fast_val = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    sa       = signed_a(funct3) && op_a[XLEN-1];
    sb       = signed_b(funct3) && op_b[XLEN-1];
    a_mag    = sa ? -op_a : op_a;
    b_mag    = sb ? -op_b : op_b;
    nxt      = flush ? S_IDLE :
               state == S_IDLE ? (accept ? (special ? S_DONE : S_CALC) : S_IDLE) :
               state == S_CALC ? (cnt == '0 ? S_FIX : S_CALC) :
               state == S_FIX  ? S_DONE : S_IDLE;
    stall    = (state == S_IDLE && start) || state == S_CALC || state == S_FIX;
    busy     = state != S_IDLE;
    done     = state == S_DONE;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end
  // iteration counter, latched op info and the held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        cnt   <= CNT_W'(XLEN - 1);
        f3_q  <= funct3;
        neg_q <= (funct3[2] && funct3[1]) ? sa : sa ^ sb;
      end else if (state == S_CALC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (accept && special) result <= fast_val;
      else if (state == S_FIX && !flush) result <= dp_res;
    end
  end
  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && !special),
    .step    (state == S_CALC),
    .is_div  (f3_q[2]),
    .fix_sign(state == S_FIX),
    .neg     (neg_q),
    .sel_hi  (f3_q[2] ? f3_q[1] : f3_q != 3'b000),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .res     (dp_res)
  );
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of the RV32M unit against an arithmetic reference model
module tb_muldiv_sequencer;
  logic        clk, rst, start, flush, stall, busy, done;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  int checks = 0, failures = 0;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic ov;
    ov = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'd0: p = {32'b0, a} * {32'b0, b};
      3'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      3'd2: p = {{32{a[31]}}, a} * {32'b0, b};
      3'd3: p = {32'b0, a} * {32'b0, b};
      3'd4: p = {32'b0, (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'($signed(a) / $signed(b))};
      3'd5: p = {32'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
      3'd6: p = {32'b0, (b == 0) ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b))};
      default: p = {32'b0, (b == 0) ? a : a % b};
    endcase
    return (f >= 3'd1 && f <= 3'd3) ? p[63:32] : p[31:0];
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // starts an op at #1 after an edge (cycle 0); returns at #1 after the edge following DONE
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    int cyc, nstall;
    logic [31:0] exp;
    exp = model(f, a, b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    check({tag, " stall_c0"}, 32'(stall), 32'd1);
    @(posedge clk); #1 start = 1'b0;
    nstall = 0;
    for (cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done) break;
      if (stall) nstall++;
      @(posedge clk); #1;
    end
    check({tag, " latency"}, 32'(cyc), 32'(latency(f, a, b)));
    check({tag, " stall_cycles"}, 32'(nstall), 32'(latency(f, a, b) - 1));
    check({tag, " result"}, result, exp);
    check({tag, " stall_in_done"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " idle_after"}, 32'(busy), 32'd0);
    check({tag, " result_held"}, result, exp);
  endtask

  initial begin
    logic [31:0] a, b, held, rres;
    logic [2:0]  f;
    int ndone, dcyc;
    rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    #2 rst = 1'b1;
    #2;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset result", result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    do_op(3'd0, 32'd7, 32'd6, "MUL 7*6");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH -1*-1");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, "MULHSU -1*2");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "REM -7%2");
    do_op(3'd5, 32'hFFFF_FFF9, 32'd2, "DIVU");
    do_op(3'd4, 32'd5, 32'd0, "DIV 5/0");
    do_op(3'd6, 32'd5, 32'd0, "REM 5%0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");

    // flush mid-MUL: no done for the killed op, result untouched, then a fresh DIVU
    held = result;
    funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0;
    repeat (9) begin
      @(negedge clk); if (done) ndone++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk); if (done) ndone++;
    @(posedge clk); #1 flush = 1'b0;
    check("flush busy_c11", 32'(busy), 32'd0);
    @(negedge clk); if (done) ndone++;
    check("flush no_done", 32'(ndone), 32'd0);
    check("flush result_held", result, held);
    @(posedge clk); #1;
    do_op(3'd5, 32'd100, 32'd7, "DIVU 100/7 after flush");

    // flush together with start in IDLE: nothing accepted
    held = result;
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    check("flush+start busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("flush+start result", result, held);

    // flush while in DONE: done still visible that cycle
    funct3 = 3'd4; op_a = 32'd9; op_b = 32'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush in DONE done", 32'(done), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    check("flush in DONE busy", 32'(busy), 32'd0);
    check("flush in DONE result", result, 32'hFFFF_FFFF);

    // start toggled while computing: exactly one done
    a = $urandom; b = $urandom;
    funct3 = 3'd0; op_a = a; op_b = b; start = 1'b1;
    ndone = 0; dcyc = 0; rres = '0;
    for (int c = 1; c <= 44; c++) begin
      @(posedge clk); #1 start = (c >= 2 && c <= 30) ? c[0] : 1'b0;
      op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      if (done) begin ndone++; dcyc = c; rres = result; end
    end
    @(posedge clk); #1;
    check("toggle done_count", 32'(ndone), 32'd1);
    check("toggle done_cycle", 32'(dcyc), 32'd34);
    check("toggle result", rres, model(3'd0, a, b));

    // async reset mid-operation
    funct3 = 3'd4; op_a = $urandom; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst stall", 32'(stall), 32'd0);
    check("async rst result", result, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_op(3'd6, 32'hFFFF_FF9C, 32'd7, "REM after rst");

    // randomized ops, with divide-by-zero and signed overflow mixed in
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(f, a, b, $sformatf("rand%0d f3=%0d", i, f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
